// File: rtl/golomb_decode_ctrl.sv
// golomb_decode_ctrl: sequences one block through the Golomb decoder.
// Ports: clk/rstn, start+blk_len command, upstream word_valid/word_data/
// word_ready, decoder dec_bitstream/dec_validin/dec_m/dec_ready/dec_n,
// symbol sym_valid/sym/sym_last, status done/busy/underrun.
module golomb_decode_ctrl #(
    parameter int A_INIT  = 4,
    parameter int RESET_N = 64,
    parameter int LEN_W   = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [LEN_W-1:0] blk_len,
    input  logic             word_valid,
    input  logic [31:0]      word_data,
    output logic             word_ready,
    output logic [31:0]      dec_bitstream,
    output logic             dec_validin,
    output logic [2:0]       dec_m,
    input  logic             dec_ready,
    input  logic [8:0]       dec_n,
    output logic             sym_valid,
    output logic [8:0]       sym,
    output logic             sym_last,
    output logic             done,
    output logic             busy,
    output logic             underrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_DECODE,
        S_FIN
    } state_t;

    // Smallest k with (n << k) >= a; saturates at 7.
    function automatic logic [2:0] kfn(
        input logic [16:0] a,
        input logic [6:0]  n
    );
        logic [2:0] k;
        k = 3'd7;
        for (int i = 6; i >= 0; i--) begin
            if (({10'd0, n} << i) >= a) begin
                k = 3'(i);
            end
        end
        return k;
    endfunction

    localparam logic [16:0] A0   = 17'(A_INIT);
    localparam logic [2:0]  M0   = kfn(A0, 7'd1);
    localparam logic [7:0]  NRST = 8'(RESET_N);

    state_t           state_q;
    state_t           state_d;
    logic [16:0]      a_q;
    logic [6:0]       n_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;

    logic [16:0]      a_sum;
    logic [16:0]      a_nxt;
    logic [7:0]       n_inc;
    logic [6:0]       n_nxt;
    logic             last;

    // Context for the symbol after the current one.
    always_comb begin
        a_sum = a_q + 17'(dec_n);
        n_inc = {1'b0, n_q} + 8'd1;
        a_nxt = a_sum;
        n_nxt = n_inc[6:0];
        if (n_inc == NRST) begin
            a_nxt = a_sum >> 1;
            n_nxt = n_inc[7:1];
        end
    end

    assign last = (cnt_q == len_q - LEN_W'(1));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        word_ready    = 1'b0;
        dec_validin   = 1'b0;
        dec_bitstream = '0;
        sym_valid     = 1'b0;
        sym           = '0;
        sym_last      = 1'b0;
        done          = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_PRIME;
                end
            end
            S_PRIME: begin
                word_ready = word_valid;
                if (word_valid) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                word_ready = dec_ready & word_valid;
                sym_valid  = 1'b1;
                sym        = dec_n;
                if (last) begin
                    sym_last = 1'b1;
                    state_d  = S_FIN;
                end
            end
            S_FIN: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // The decoder strobe is exactly the upstream accept.
        dec_validin = word_ready;
        if (word_ready) begin
            dec_bitstream = word_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            a_q      <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            dec_m    <= '0;
            busy     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            busy <= (state_d != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        // A zero length still decodes one symbol.
                        len_q    <= (blk_len == '0) ? LEN_W'(1) : blk_len;
                        a_q      <= A0;
                        n_q      <= 7'd1;
                        cnt_q    <= '0;
                        dec_m    <= M0;
                        underrun <= 1'b0;
                    end
                end
                S_DECODE: begin
                    a_q   <= a_nxt;
                    n_q   <= n_nxt;
                    dec_m <= kfn(a_nxt, n_nxt);
                    cnt_q <= cnt_q + LEN_W'(1);
                    if (dec_ready & ~word_valid) begin
                        underrun <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/golomb_decode_ctrl.md
# golomb_decode_ctrl

Sequencing controller for the Golomb symbol decoder in the image decompression path. It takes a start command with a block length and feeds 32-bit compressed words from an upstream source into the decoder whenever the decoder can accept them. It drives the per-symbol divisor exponent `m` from a LOCO-style adaptive context (`A`, `N`) and counts decoded symbols. It emits each decoded value with valid/last flags and reports block completion and input underrun.

## Interface
Parameters:
- `A_INIT`, default 4: initial accumulator value at block start.
- `RESET_N`, default 64: when `N` reaches this value, `A` and `N` are halved.
- `LEN_W`, default 12: width of the block length.

Ports:
- `clk`, input, 1: clock.
- `rstn`, input, 1: asynchronous active-low reset.
- `start`, input, 1: block start pulse. Ignored unless in IDLE.
- `blk_len`, input, `LEN_W`: number of symbols in the block. Sampled on an accepted `start`. The value 0 is treated as 1.
- `word_valid`, input, 1: upstream compressed word available.
- `word_data`, input, 32: upstream compressed word, MSB first.
- `word_ready`, output, 1: word accepted this cycle.
- `dec_bitstream`, output, 32: word forwarded to the decoder.
- `dec_validin`, output, 1: decoder word strobe.
- `dec_m`, output, 3: decoder divisor exponent.
- `dec_ready`, input, 1: decoder buffer holds ≤32 bits.
- `dec_n`, input, 9: decoder's current decoded value.
- `sym_valid`, output, 1: `sym` is valid this cycle.
- `sym`, output, 9: decoded symbol.
- `sym_last`, output, 1: final symbol of the block.
- `done`, output, 1: one-cycle pulse after the last symbol.
- `busy`, output, 1: high in any state other than IDLE.
- `underrun`, output, 1: sticky flag, cleared by `start`.

## Operation
- States: IDLE, PRIME, DECODE, DONE.
- **IDLE**
  - On `start`: latch `blk_len`, set `A=A_INIT`, `N=1`, `cnt=0`, `dec_m=k(A_INIT,1)`, clear `underrun`, go to PRIME.
- **PRIME**
  - `word_ready = word_valid`.
  - On accept: `dec_validin=1` and `dec_bitstream=word_data` in the same cycle, then go to DECODE.
  - No symbols are produced in PRIME.
- **DECODE**
  - Every cycle is one symbol: `sym_valid=1`, `sym=dec_n`.
  - Word forwarding: `word_ready = dec_ready & word_valid`. On accept, `dec_validin=1` and `dec_bitstream=word_data` in the same cycle.
  - If `dec_ready & !word_valid`, set `underrun`. Decoding continues regardless.
  - Context update per symbol:
    - `A' = A + dec_n` and `N' = N + 1`.
    - If `N' == RESET_N`: `A' = A' >> 1` and `N' = N' >> 1`.
    - The registered `dec_m` for the next symbol is `k(A', N')`.
  - `k(A,N)` is the smallest `k` in 0..7 with `(N << k) >= A`, otherwise 7.
  - Width of `A` is 17 bits, which is sufficient for the default `RESET_N`. Width of `N` is 7 bits.
  - `cnt` increments per symbol. When `cnt == len-1`: `sym_last=1`, go to DONE.
- **DONE**
  - `done=1` for one cycle, then go to IDLE.
  - `word_ready=0`. Unconsumed words stay upstream.
- `start` outside IDLE is ignored.
- Reset asserted at any point (async): return to IDLE immediately and drive every output to 0. Context and counters clear.

## Timing
- Reset values: `word_ready`, `dec_validin`, `dec_bitstream`, `dec_m`, `sym_valid`, `sym`, `sym_last`, `done`, `busy`, `underrun` are all 0.
- `dec_m`, `busy` and `underrun` are registered.
- `word_ready`, `dec_validin` and `dec_bitstream` are combinational from state and inputs.
- `sym`, `sym_valid` and `sym_last` are combinational from `dec_n` and state.
- Cycle sequence:
  - `start` at cycle t.
  - PRIME from t+1.
  - Word accepted at cycle p ≥ t+1.
  - First symbol at p+1.
  - Symbol i at p+1+i.
  - `done` at p+1+len.
- `busy` is high from t+1 through the DONE cycle.
- The context update and `dec_m` change take effect on the edge following each symbol cycle. `dec_m` is stable for the whole symbol cycle.
- Simultaneous `N'==RESET_N` and last symbol: the update still occurs. It is harmless because context reloads on the next `start`.

## Test plan
- **Adaptive m:** `start`, `blk_len=3`, decoder returns n=5,0,12.
  - `dec_m` = 2, 3, 2 on the three symbol cycles.
  - `sym_last` on the third symbol; `done` one cycle later.
- **Halving:** `blk_len=70`, all n=0.
  - `dec_m` reaches 0 by the 4th symbol.
  - After symbol 63, internal `N=32`, `A=2`.
  - `dec_m` stays 0 through 70 symbols; exactly 70 `sym_valid` cycles.
- **Word gating:** `word_valid` held high, `dec_ready` toggling 1,0,1.
  - `word_ready` and `dec_validin` equal to `dec_ready` in DECODE.
  - `dec_bitstream` equals `word_data` on each accept.
- **Underrun:** in DECODE, `dec_ready=1` and `word_valid=0` for one cycle.
  - `underrun=1` from the next cycle, stays set until the next `start`.
- **Ignored start:** pulse `start` mid-block.
  - No restart; symbol count and `done` timing unchanged.
  - `blk_len=0` → one symbol.
- **Async reset:** assert `rstn=0` mid-DECODE.
  - All outputs 0 immediately; IDLE after release; a new `start` works normally.
